// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler and the stage registers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hazard_state_e;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

  // addi x0, x0, 0 -- the bubble a flushed stage register loads
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc,
  output logic [PERF_W-1:0] o_count
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {PERF_W{1'b1}})) begin
      count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Stage-enable/flush scheduler for the 5-stage core: load-use stalls, mispredict flushes,
// data-memory freeze and a watchdog. Optional perf counters build under HAZARD_PERF_EN.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int PERF_W      = 32,
  localparam int WCW        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [4:0]        i_id_rs1_addr,
  input  logic [4:0]        i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [4:0]        i_ex_rd_addr,
  input  logic              i_ex_mem_rden,
  input  logic              i_ex_br_mispred,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_mem_wb_flush,
  output logic              o_pc_redirect,
  output logic              o_mem_timeout,
  output logic [PERF_W-1:0] o_lu_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt,
  output logic [PERF_W-1:0] o_wait_cnt,
  output hazard_state_e     o_dbg_state,
  output logic [WCW-1:0]    o_dbg_wait_cnt
);

  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MEM_TIMEOUT);

  hazard_state_e  state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic lu;
  logic mw;
  logic frozen;

  // Memory handshake: a MEM access with i_mem_req high completes in the cycle i_mem_ack is
  // high; every req cycle without ack is a wait cycle and freezes everything upstream of WB.
  assign mw = i_mem_req & ~i_mem_ack;

  assign lu = i_ex_mem_rden && (i_ex_rd_addr != 5'd0) &&
              ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
               (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  assign frozen = (state_q == HALT) || mw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mw) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_d = RUN;
        end else if (mw && (wait_q == WAIT_LAST)) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Held at MEM_TIMEOUT once halted so a stuck request cannot wrap the count.
  always_comb begin
    wait_d = '0;
    if (mw) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + {{(WCW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_id_ex_en     = 1'b1;
    o_ex_mem_en    = 1'b1;
    o_mem_wb_en    = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;
    o_pc_redirect  = 1'b0;
    if (i_reset) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_mem_wb_flush = 1'b1;
    end else if (frozen) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_flush = 1'b1;
    end else if (i_ex_br_mispred) begin
      // The ID instruction is wrong-path, so a coincident load-use stall is moot.
      o_pc_redirect  = 1'b1;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
    end else if (lu) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_flush  = 1'b1;
    end
  end

  assign o_mem_timeout  = (state_q == HALT);
  assign o_dbg_state    = state_q;
  assign o_dbg_wait_cnt = wait_q;

`ifdef HAZARD_PERF_EN
  logic lu_stall;
  logic br_flush;
  logic frz_cycle;

  assign lu_stall  = ~i_reset & ~frozen & ~i_ex_br_mispred & lu;
  assign br_flush  = ~i_reset & ~frozen & i_ex_br_mispred;
  assign frz_cycle = ~i_reset & frozen;

  hazard_sat_counter #(.PERF_W(PERF_W)) u_lu_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (lu_stall),
    .o_count (o_lu_stall_cnt)
  );

  hazard_sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (br_flush),
    .o_count (o_flush_cnt)
  );

  hazard_sat_counter #(.PERF_W(PERF_W)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (frz_cycle),
    .o_count (o_wait_cnt)
  );
`else
  assign o_lu_stall_cnt = '0;
  assign o_flush_cnt    = '0;
  assign o_wait_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler (MEM_TIMEOUT=4, PERF_W=4), directed plus random.
module tb_hazard_scheduler;
  import hazard_pkg::*;

  localparam int MT   = 4;
  localparam int PW   = 4;
  localparam int WCW  = $clog2(MT + 1);
  localparam int CMAX = (1 << PW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, rden, mis, req, ack;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, mem_timeout;
  logic [PW-1:0]  lu_cnt, fl_cnt, wt_cnt;
  hazard_state_e  dbg_state;
  logic [WCW-1:0] dbg_wait;

  hazard_scheduler #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_id_rs1_addr   (rs1),
    .i_id_rs2_addr   (rs2),
    .i_id_rs1_used   (u1),
    .i_id_rs2_used   (u2),
    .i_ex_rd_addr    (rd),
    .i_ex_mem_rden   (rden),
    .i_ex_br_mispred (mis),
    .i_mem_req       (req),
    .i_mem_ack       (ack),
    .o_pc_en         (pc_en),
    .o_if_id_en      (if_id_en),
    .o_id_ex_en      (id_ex_en),
    .o_ex_mem_en     (ex_mem_en),
    .o_mem_wb_en     (mem_wb_en),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_flush   (id_ex_flush),
    .o_mem_wb_flush  (mem_wb_flush),
    .o_pc_redirect   (pc_redirect),
    .o_mem_timeout   (mem_timeout),
    .o_lu_stall_cnt  (lu_cnt),
    .o_flush_cnt     (fl_cnt),
    .o_wait_cnt      (wt_cnt),
    .o_dbg_state     (dbg_state),
    .o_dbg_wait_cnt  (dbg_wait)
  );

  wire [9:0]      obs_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                             if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, mem_timeout};
  wire [3*PW-1:0] obs_cnt = {lu_cnt, fl_cnt, wt_cnt};

  // Reference model: a sticky halted flag, a run length of unacknowledged cycles, event tallies.
  bit m_halted;
  int m_run;
  int m_lu, m_fl, m_wt;
  int errors = 0;
  int checks = 0;

  function automatic bit m_lu_hit();
    return rden && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic logic [9:0] exp_ctl();
    bit stall_all = m_halted || (req && !ack);
    bit [4:0] en = 5'b11111;
    bit fi = 0, fd = 0, fw = 0, rdr = 0;
    if (rst) begin
      fi = 1; fd = 1; fw = 1;
    end else if (stall_all) begin
      en = 5'b00001; fw = 1;
    end else if (mis) begin
      rdr = 1; fi = 1; fd = 1;
    end else if (m_lu_hit()) begin
      en = 5'b00111; fd = 1;
    end
    return {en, fi, fd, fw, rdr, m_halted};
  endfunction

  function automatic logic [3*PW-1:0] exp_cnt();
    if (!PERF) return '0;
    return {PW'(m_lu), PW'(m_fl), PW'(m_wt)};
  endfunction

  task automatic apply(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e1, input logic e2, input logic [4:0] d, input logic ld,
                       input logic mp, input logic rq, input logic ak);
    rst = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; rden = ld;
    mis = mp; req = rq; ack = ak;
    #1;
  endtask

  task automatic tick();
    bit stall_all;
    @(posedge clk);
    stall_all = m_halted || (req && !ack);
    if (rst) begin
      m_halted = 0; m_run = 0; m_lu = 0; m_fl = 0; m_wt = 0;
    end else begin
      if (stall_all)        m_wt = (m_wt < CMAX) ? m_wt + 1 : m_wt;
      else if (mis)         m_fl = (m_fl < CMAX) ? m_fl + 1 : m_fl;
      else if (m_lu_hit())  m_lu = (m_lu < CMAX) ? m_lu + 1 : m_lu;
      m_run = (req && !ack) ? m_run + 1 : 0;
      if (m_run >= MT) m_halted = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (obs_ctl !== exp_ctl()) begin
      errors++; $display("FAIL reset_ctl got=%b exp=%b", obs_ctl, exp_ctl());
    end
    checks++;
    if ({if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect} !== 4'b1110) begin
      errors++; $display("FAIL reset_flush got=%b exp=1110",
                         {if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect});
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_ctl !== 10'b11111_0000_0) begin
      errors++; $display("FAIL reset_release got=%b exp=1111100000", obs_ctl);
    end
    checks++;
    if (obs_cnt !== '0 || dbg_state !== RUN || dbg_wait !== '0) begin
      errors++; $display("FAIL reset_state got=%h/%0d/%0d exp=0/0/0", obs_cnt, dbg_state, dbg_wait);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(0, 5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0);
    checks++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b001 || obs_ctl !== exp_ctl()) begin
      errors++; $display("FAIL lu_stall got=%b exp=%b", obs_ctl, exp_ctl());
    end
    tick();
    apply(0, 5'd3, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0);
    checks++;
    if (obs_ctl !== 10'b11111_0000_0) begin
      errors++; $display("FAIL lu_next got=%b exp=1111100000", obs_ctl);
    end
    checks++;
    if (lu_cnt !== (PERF ? PW'(1) : PW'(0)) || obs_cnt !== exp_cnt()) begin
      errors++; $display("FAIL lu_count got=%h exp=%h", obs_cnt, exp_cnt());
    end
    tick();
  endtask

  task automatic test_no_stall_cases();
    apply(0, 5'd0, 5'd9, 1, 1, 5'd0, 1, 0, 0, 0);
    checks++;
    if (obs_ctl !== 10'b11111_0000_0) begin
      errors++; $display("FAIL lu_x0 got=%b exp=1111100000", obs_ctl);
    end
    tick();
    apply(0, 5'd7, 5'd9, 0, 1, 5'd7, 1, 0, 0, 0);
    checks++;
    if (obs_ctl !== 10'b11111_0000_0) begin
      errors++; $display("FAIL lu_unused got=%b exp=1111100000", obs_ctl);
    end
    tick();
  endtask

  task automatic test_mispred_lu();
    do_reset();
    apply(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    checks++;
    if ({pc_redirect, if_id_flush, id_ex_flush, pc_en} !== 4'b1111 || obs_ctl !== exp_ctl()) begin
      errors++; $display("FAIL mis_lu got=%b exp=%b", obs_ctl, exp_ctl());
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (lu_cnt !== '0 || obs_cnt !== exp_cnt()) begin
      errors++; $display("FAIL mis_lu_cnt got=%h exp=%h", obs_cnt, exp_cnt());
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      checks++;
      if ({pc_en, ex_mem_en, mem_wb_flush, pc_redirect} !== 4'b0010 || obs_ctl !== exp_ctl()) begin
        errors++; $display("FAIL mw_frozen%0d got=%b exp=%b", i, obs_ctl, exp_ctl());
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (pc_redirect !== 1'b1 || obs_ctl !== exp_ctl()) begin
      errors++; $display("FAIL mw_ack got=%b exp=%b", obs_ctl, exp_ctl());
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dbg_state !== RUN || wt_cnt !== (PERF ? PW'(3) : PW'(0)) || obs_cnt !== exp_cnt()) begin
      errors++; $display("FAIL mw_after got=%0d/%h exp=0/%h", dbg_state, obs_cnt, exp_cnt());
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < MT; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (mem_timeout !== 1'b0 || obs_ctl !== exp_ctl()) begin
        errors++; $display("FAIL to_pre%0d got=%b exp=%b", i, obs_ctl, exp_ctl());
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (mem_timeout !== 1'b1 || pc_en !== 1'b0 || dbg_state !== HALT || obs_ctl !== exp_ctl()) begin
        errors++; $display("FAIL to_halt%0d got=%b exp=%b", i, obs_ctl, exp_ctl());
      end
      tick();
    end
    checks++;
    if (obs_cnt !== exp_cnt()) begin
      errors++; $display("FAIL to_cnt got=%h exp=%h", obs_cnt, exp_cnt());
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    apply(0, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0);
    tick();
    tick();
    checks++;
    if (dbg_state !== MEM_WAIT || dbg_wait !== WCW'(2)) begin
      errors++; $display("FAIL rmw_pre got=%0d/%0d exp=1/2", dbg_state, dbg_wait);
    end
    apply(1, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0);
    checks++;
    if ({if_id_flush, id_ex_flush, mem_wb_flush} !== 3'b111 || obs_ctl !== exp_ctl()) begin
      errors++; $display("FAIL rmw_during got=%b exp=%b", obs_ctl, exp_ctl());
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dbg_state !== RUN || dbg_wait !== '0 || obs_cnt !== '0) begin
      errors++; $display("FAIL rmw_after got=%0d/%0d/%h exp=0/0/0", dbg_state, dbg_wait, obs_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (lu_cnt !== (PERF ? PW'(CMAX) : PW'(0)) || obs_cnt !== exp_cnt()) begin
      errors++; $display("FAIL sat got=%h exp=%h", obs_cnt, exp_cnt());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 31) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      checks++;
      if (obs_ctl !== exp_ctl()) begin
        errors++; $display("FAIL rnd_ctl%0d got=%b exp=%b", i, obs_ctl, exp_ctl());
      end
      checks++;
      if (obs_cnt !== exp_cnt()) begin
        errors++; $display("FAIL rnd_cnt%0d got=%h exp=%h", i, obs_cnt, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    m_halted = 0; m_run = 0; m_lu = 0; m_fl = 0; m_wt = 0;
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_mispred_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
